// File: rtl/alt_mem_ddrx_itf_master.sv
// alt_mem_ddrx_itf_master
//   Requester-side master for the controller's native local interface.
//   It turns an Avalon-MM burst master port into registered itf_cmd and
//   itf_wr_data beats, and tags every command with a rolling local ID.
//   It also caps the number of outstanding reads and returns read data
//   to the Avalon side one cycle after the controller presents it.
// Ports:
//   ctl_clk / ctl_reset_n  : single clock, async active-low reset
//   local_init_done        : controller ready, gates new accepts
//   avl_*                  : Avalon-MM burst slave side (avl_ready = waitrequest_n)
//   itf_cmd_*              : command channel (valid/ready, registered)
//   itf_wr_data_*          : write data channel (valid/ready, registered)
//   itf_rd_data_*          : read return channel (always accepted)
module alt_mem_ddrx_itf_master #(
  parameter int CFG_LOCAL_DATA_WIDTH = 64,
  parameter int CFG_LOCAL_ADDR_WIDTH = 33,
  parameter int CFG_LOCAL_SIZE_WIDTH = 3,
  parameter int CFG_LOCAL_ID_WIDTH   = 8,
  parameter int CFG_MAX_PENDING_RD   = 16
) (
  input  logic                              ctl_clk,
  input  logic                              ctl_reset_n,
  input  logic                              local_init_done,
  output logic                              avl_ready,
  input  logic                              avl_read_req,
  input  logic                              avl_write_req,
  input  logic [CFG_LOCAL_ADDR_WIDTH-1:0]   avl_addr,
  input  logic [CFG_LOCAL_SIZE_WIDTH-1:0]   avl_size,
  input  logic [CFG_LOCAL_DATA_WIDTH-1:0]   avl_wdata,
  input  logic [CFG_LOCAL_DATA_WIDTH/8-1:0] avl_be,
  output logic [CFG_LOCAL_DATA_WIDTH-1:0]   avl_rdata,
  output logic                              avl_rdata_valid,
  output logic                              avl_rdata_error,
  input  logic                              itf_cmd_ready,
  output logic                              itf_cmd_valid,
  output logic                              itf_cmd,
  output logic [CFG_LOCAL_ADDR_WIDTH-1:0]   itf_cmd_address,
  output logic [CFG_LOCAL_SIZE_WIDTH-1:0]   itf_cmd_burstlen,
  output logic [CFG_LOCAL_ID_WIDTH-1:0]     itf_cmd_id,
  input  logic                              itf_wr_data_ready,
  output logic                              itf_wr_data_valid,
  output logic [CFG_LOCAL_DATA_WIDTH-1:0]   itf_wr_data,
  output logic [CFG_LOCAL_DATA_WIDTH/8-1:0] itf_wr_data_byte_en,
  output logic                              itf_wr_data_begin,
  output logic                              itf_wr_data_last,
  output logic [CFG_LOCAL_ID_WIDTH-1:0]     itf_wr_data_id,
  output logic                              itf_rd_data_ready,
  input  logic                              itf_rd_data_valid,
  input  logic [CFG_LOCAL_DATA_WIDTH-1:0]   itf_rd_data,
  input  logic                              itf_rd_data_error,
  input  logic                              itf_rd_data_last
);
  localparam int DW = CFG_LOCAL_DATA_WIDTH;
  localparam int AW = CFG_LOCAL_ADDR_WIDTH;
  localparam int SW = CFG_LOCAL_SIZE_WIDTH;
  localparam int IW = CFG_LOCAL_ID_WIDTH;
  localparam int BW = CFG_LOCAL_DATA_WIDTH / 8;
  localparam int PW = $clog2(CFG_MAX_PENDING_RD + 1);
  localparam logic [PW-1:0] MAX_P = PW'(CFG_MAX_PENDING_RD);

  typedef enum logic {IDLE, WDATA} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   id_cnt_q, id_cnt_d;
  logic [PW-1:0]   pending_rd_q, pending_rd_d;
  logic [SW-1:0]   beats_left_q, beats_left_d;
  // command slot
  logic            cmd_valid_q, cmd_valid_d, cmd_q, cmd_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic [SW-1:0]   cmd_len_q, cmd_len_d;
  logic [IW-1:0]   cmd_id_q, cmd_id_d;
  // write-data slot; wr_id_q doubles as the held burst ID during WDATA
  logic            wr_valid_q, wr_valid_d, wr_begin_q, wr_begin_d, wr_last_q, wr_last_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [BW-1:0]   wr_be_q, wr_be_d;
  logic [IW-1:0]   wr_id_q, wr_id_d;
  // read return
  logic [DW-1:0]   rdata_q;
  logic            rvalid_q, rerror_q;
  // 0 in reset, 1 from the first clock after release; also keeps avl_ready low in reset
  logic            run_q;

  logic            cmd_free, wr_free, ready, wr_first, wr_beat, rd_acc, rd_done;
  logic [SW-1:0]   size_eff;

  always_comb begin
    cmd_free = ~cmd_valid_q | itf_cmd_ready;
    wr_free  = ~wr_valid_q | itf_wr_data_ready;
    size_eff = (avl_size == '0) ? SW'(1) : avl_size;
    if (state_q == IDLE)
      ready = run_q & local_init_done & cmd_free & wr_free & (pending_rd_q < MAX_P);
    else
      ready = run_q & local_init_done & wr_free;
    // write wins over an (illegal) simultaneous read
    wr_first = (state_q == IDLE) & ready & avl_write_req;
    rd_acc   = (state_q == IDLE) & ready & avl_read_req & ~avl_write_req;
    wr_beat  = (state_q == WDATA) & ready & avl_write_req;
    rd_done  = itf_rd_data_valid & itf_rd_data_last & (pending_rd_q != '0);

    state_d = state_q;           id_cnt_d = id_cnt_q;
    pending_rd_d = pending_rd_q; beats_left_d = beats_left_q;
    cmd_valid_d = cmd_valid_q & ~itf_cmd_ready;
    cmd_d = cmd_q; cmd_addr_d = cmd_addr_q; cmd_len_d = cmd_len_q; cmd_id_d = cmd_id_q;
    wr_valid_d = wr_valid_q & ~itf_wr_data_ready;
    wr_begin_d = wr_begin_q; wr_last_d = wr_last_q;
    wr_data_d = wr_data_q; wr_be_d = wr_be_q; wr_id_d = wr_id_q;

    if (rd_acc | wr_first) begin
      cmd_valid_d = 1'b1;
      cmd_d       = wr_first;
      cmd_addr_d  = avl_addr;
      cmd_len_d   = size_eff;
      cmd_id_d    = id_cnt_q;
      id_cnt_d    = id_cnt_q + IW'(1);
    end
    if (wr_first) begin
      wr_valid_d   = 1'b1;
      wr_data_d    = avl_wdata;
      wr_be_d      = avl_be;
      wr_begin_d   = 1'b1;
      wr_last_d    = (size_eff == SW'(1));
      wr_id_d      = id_cnt_q;
      beats_left_d = size_eff - SW'(1);
      if (size_eff != SW'(1)) state_d = WDATA;
    end
    if (wr_beat) begin
      wr_valid_d   = 1'b1;
      wr_data_d    = avl_wdata;
      wr_be_d      = avl_be;
      wr_begin_d   = 1'b0;
      wr_last_d    = (beats_left_q == SW'(1));
      beats_left_d = beats_left_q - SW'(1);
      if (beats_left_q == SW'(1)) state_d = IDLE;
    end
    case ({rd_acc, rd_done})
      2'b10:   pending_rd_d = pending_rd_q + PW'(1);
      2'b01:   pending_rd_d = pending_rd_q - PW'(1);
      default: pending_rd_d = pending_rd_q;
    endcase
  end

  always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
    if (!ctl_reset_n) begin
      state_q <= IDLE; id_cnt_q <= '0; pending_rd_q <= '0; beats_left_q <= '0;
      cmd_valid_q <= 1'b0; cmd_q <= 1'b0; cmd_addr_q <= '0; cmd_len_q <= '0; cmd_id_q <= '0;
      wr_valid_q <= 1'b0; wr_begin_q <= 1'b0; wr_last_q <= 1'b0;
      wr_data_q <= '0; wr_be_q <= '0; wr_id_q <= '0;
      rdata_q <= '0; rvalid_q <= 1'b0; rerror_q <= 1'b0; run_q <= 1'b0;
    end else begin
      state_q <= state_d; id_cnt_q <= id_cnt_d;
      pending_rd_q <= pending_rd_d; beats_left_q <= beats_left_d;
      cmd_valid_q <= cmd_valid_d; cmd_q <= cmd_d; cmd_addr_q <= cmd_addr_d;
      cmd_len_q <= cmd_len_d; cmd_id_q <= cmd_id_d;
      wr_valid_q <= wr_valid_d; wr_begin_q <= wr_begin_d; wr_last_q <= wr_last_d;
      wr_data_q <= wr_data_d; wr_be_q <= wr_be_d; wr_id_q <= wr_id_d;
      rdata_q <= itf_rd_data; rvalid_q <= itf_rd_data_valid; rerror_q <= itf_rd_data_error;
      run_q <= 1'b1;
    end
  end

  assign avl_ready           = ready;
  assign avl_rdata           = rdata_q;
  assign avl_rdata_valid     = rvalid_q;
  assign avl_rdata_error     = rerror_q;
  assign itf_cmd_valid       = cmd_valid_q;
  assign itf_cmd             = cmd_q;
  assign itf_cmd_address     = cmd_addr_q;
  assign itf_cmd_burstlen    = cmd_len_q;
  assign itf_cmd_id          = cmd_id_q;
  assign itf_wr_data_valid   = wr_valid_q;
  assign itf_wr_data         = wr_data_q;
  assign itf_wr_data_byte_en = wr_be_q;
  assign itf_wr_data_begin   = wr_begin_q;
  assign itf_wr_data_last    = wr_last_q;
  assign itf_wr_data_id      = wr_id_q;
  assign itf_rd_data_ready   = run_q;
endmodule

// File: tb/tb_alt_mem_ddrx_itf_master.sv
module tb_alt_mem_ddrx_itf_master;
  logic        clk = 1'b0;
  logic        rst_n, init_done, avl_ready, rd_req, wr_req;
  logic [32:0] addr;
  logic [2:0]  size;
  logic [63:0] wdata, rdata, itf_rdata, itf_wdata;
  logic [7:0]  be, itf_be;
  logic        rvalid, rerror, cmd_ready, cmd_valid, cmd;
  logic [32:0] cmd_addr;
  logic [2:0]  cmd_len;
  logic [7:0]  cmd_id, wr_id;
  logic        wr_ready, wr_valid, wr_begin, wr_last, rd_ready;
  logic        itf_rvalid, itf_rerror, itf_rlast;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_id = 8'd0;

  always #5 clk = ~clk;

  alt_mem_ddrx_itf_master dut (
    .ctl_clk(clk), .ctl_reset_n(rst_n), .local_init_done(init_done),
    .avl_ready(avl_ready), .avl_read_req(rd_req), .avl_write_req(wr_req),
    .avl_addr(addr), .avl_size(size), .avl_wdata(wdata), .avl_be(be),
    .avl_rdata(rdata), .avl_rdata_valid(rvalid), .avl_rdata_error(rerror),
    .itf_cmd_ready(cmd_ready), .itf_cmd_valid(cmd_valid), .itf_cmd(cmd),
    .itf_cmd_address(cmd_addr), .itf_cmd_burstlen(cmd_len), .itf_cmd_id(cmd_id),
    .itf_wr_data_ready(wr_ready), .itf_wr_data_valid(wr_valid), .itf_wr_data(itf_wdata),
    .itf_wr_data_byte_en(itf_be), .itf_wr_data_begin(wr_begin), .itf_wr_data_last(wr_last),
    .itf_wr_data_id(wr_id), .itf_rd_data_ready(rd_ready), .itf_rd_data_valid(itf_rvalid),
    .itf_rd_data(itf_rdata), .itf_rd_data_error(itf_rerror), .itf_rd_data_last(itf_rlast)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_done = 1'b1; rd_req = 1'b0; wr_req = 1'b0;
    addr = '0; size = '0; wdata = '0; be = 8'hFF;
    cmd_ready = 1'b1; wr_ready = 1'b1;
    itf_rvalid = 1'b0; itf_rdata = '0; itf_rerror = 1'b0; itf_rlast = 1'b0;
    #12;
    total++;
    if ({avl_ready, cmd_valid, wr_valid, rvalid, rerror, rd_ready, cmd_id, wr_id} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0",
        {avl_ready, cmd_valid, wr_valid, rvalid, rerror, rd_ready, cmd_id, wr_id});
    end
    #3 rst_n = 1'b1;
    tick();
    total++;
    if ({rd_ready, avl_ready} !== 2'b11) begin
      bad++; $display("FAIL reset_release got=%b exp=11", {rd_ready, avl_ready});
    end
  endtask

  task automatic test_read();
    rd_req = 1'b1; addr = 33'h100; size = 3'd2; #1;
    total++;
    if (avl_ready !== 1'b1) begin bad++; $display("FAIL rd_ready_idle got=%b exp=1", avl_ready); end
    tick(); rd_req = 1'b0;
    total++;
    if ({cmd_valid, cmd, cmd_addr, cmd_len, cmd_id} !== {1'b1, 1'b0, 33'h100, 3'd2, exp_id}) begin
      bad++; $display("FAIL rd_cmd got=%h exp=%h", {cmd_valid, cmd, cmd_addr, cmd_len, cmd_id},
        {1'b1, 1'b0, 33'h100, 3'd2, exp_id});
    end
    exp_id++;
    itf_rvalid = 1'b1; itf_rdata = 64'h11; itf_rlast = 1'b0;
    tick();
    total++;
    if ({cmd_valid, rvalid, rerror, rdata} !== {1'b0, 1'b1, 1'b0, 64'h11}) begin
      bad++; $display("FAIL rd_beat0 got=%h exp=%h", {cmd_valid, rvalid, rerror, rdata},
        {1'b0, 1'b1, 1'b0, 64'h11});
    end
    itf_rdata = 64'h22; itf_rlast = 1'b1; itf_rerror = 1'b1;
    tick();
    total++;
    if ({rvalid, rerror, rdata} !== {1'b1, 1'b1, 64'h22}) begin
      bad++; $display("FAIL rd_beat1 got=%h exp=%h", {rvalid, rerror, rdata}, {1'b1, 1'b1, 64'h22});
    end
    itf_rvalid = 1'b0; itf_rlast = 1'b0; itf_rerror = 1'b0;
    tick();
    total++;
    if (rvalid !== 1'b0) begin bad++; $display("FAIL rd_valid_drop got=%b exp=0", rvalid); end
  endtask

  task automatic test_write();
    logic [7:0] id;
    id = exp_id;
    wr_req = 1'b1; addr = 33'h1_0000_0040; size = 3'd4; wdata = 64'hA0; be = 8'h0F; #1;
    total++;
    if (avl_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_idle got=%b exp=1", avl_ready); end
    tick();
    total++;
    if ({cmd_valid, cmd, cmd_addr, cmd_len, cmd_id} !== {1'b1, 1'b1, 33'h1_0000_0040, 3'd4, id}) begin
      bad++; $display("FAIL wr_cmd got=%h exp=%h", {cmd_valid, cmd, cmd_addr, cmd_len, cmd_id},
        {1'b1, 1'b1, 33'h1_0000_0040, 3'd4, id});
    end
    total++;
    if ({wr_valid, itf_wdata, itf_be, wr_begin, wr_last, wr_id} !== {1'b1, 64'hA0, 8'h0F, 1'b1, 1'b0, id}) begin
      bad++; $display("FAIL wr_beat0 got=%h exp=%h", {wr_valid, itf_wdata, itf_be, wr_begin, wr_last, wr_id},
        {1'b1, 64'hA0, 8'h0F, 1'b1, 1'b0, id});
    end
    exp_id++;
    for (int k = 1; k < 4; k++) begin
      wdata = 64'hA0 + 64'(k); size = 3'd7; rd_req = (k == 2);
      tick();
      total++;
      if ({wr_valid, itf_wdata, wr_begin, wr_last, wr_id} !== {1'b1, 64'hA0 + 64'(k), 1'b0, (k == 3), id}) begin
        bad++; $display("FAIL wr_beat%0d got=%h exp=%h", k, {wr_valid, itf_wdata, wr_begin, wr_last, wr_id},
          {1'b1, 64'hA0 + 64'(k), 1'b0, (k == 3), id});
      end
    end
    wr_req = 1'b0; rd_req = 1'b0;
    tick();
    total++;
    if ({cmd_valid, wr_valid} !== 2'b00) begin
      bad++; $display("FAIL wr_drain got=%b exp=00", {cmd_valid, wr_valid});
    end
    // size 0 behaves as a single beat: begin and last together, back in IDLE
    wr_req = 1'b1; size = 3'd0; wdata = 64'hB5;
    tick(); wr_req = 1'b0;
    total++;
    if ({cmd_len, cmd_id, wr_begin, wr_last, wr_id, itf_wdata} !== {3'd1, exp_id, 1'b1, 1'b1, exp_id, 64'hB5}) begin
      bad++; $display("FAIL wr_size0 got=%h exp=%h", {cmd_len, cmd_id, wr_begin, wr_last, wr_id, itf_wdata},
        {3'd1, exp_id, 1'b1, 1'b1, exp_id, 64'hB5});
    end
    exp_id++;
    #1;
    total++;
    if (avl_ready !== 1'b1) begin bad++; $display("FAIL wr_idle_again got=%b exp=1", avl_ready); end
    tick();
  endtask

  task automatic test_backpressure();
    cmd_ready = 1'b0; rd_req = 1'b1; addr = 33'h55; size = 3'd1;
    tick(); rd_req = 1'b0; addr = 33'h77;
    for (int c = 0; c < 5; c++) begin
      #1;
      total++;
      if ({avl_ready, cmd_valid, cmd, cmd_addr, cmd_id} !== {1'b0, 1'b1, 1'b0, 33'h55, exp_id}) begin
        bad++; $display("FAIL bp_hold%0d got=%h exp=%h", c, {avl_ready, cmd_valid, cmd, cmd_addr, cmd_id},
          {1'b0, 1'b1, 1'b0, 33'h55, exp_id});
      end
      tick();
    end
    exp_id++;
    cmd_ready = 1'b1; #1;
    total++;
    if (avl_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", avl_ready); end
    tick();
    total++;
    if (cmd_valid !== 1'b0) begin bad++; $display("FAIL bp_issued got=%b exp=0", cmd_valid); end
    itf_rvalid = 1'b1; itf_rlast = 1'b1;
    tick(); itf_rvalid = 1'b0; itf_rlast = 1'b0;
  endtask

  task automatic test_max_pending();
    // completion with nothing outstanding must not underflow
    itf_rvalid = 1'b1; itf_rlast = 1'b1;
    tick(); itf_rvalid = 1'b0; itf_rlast = 1'b0;
    rd_req = 1'b1; addr = 33'h300; size = 3'd1; #1;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (avl_ready !== 1'b1) begin bad++; $display("FAIL fill_ready%0d got=%b exp=1", i, avl_ready); end
      tick();
      total++;
      if (cmd_id !== exp_id) begin bad++; $display("FAIL fill_id%0d got=%h exp=%h", i, cmd_id, exp_id); end
      exp_id++;
    end
    total++;
    if (avl_ready !== 1'b0) begin bad++; $display("FAIL full_stall got=%b exp=0", avl_ready); end
    tick();
    total++;
    if ({avl_ready, cmd_valid} !== 2'b00) begin
      bad++; $display("FAIL full_hold got=%b exp=00", {avl_ready, cmd_valid});
    end
    itf_rvalid = 1'b1; itf_rlast = 1'b1; #1;
    total++;
    if (avl_ready !== 1'b0) begin bad++; $display("FAIL full_cmpl_cycle got=%b exp=0", avl_ready); end
    tick();
    total++;
    if (avl_ready !== 1'b1) begin bad++; $display("FAIL reenable got=%b exp=1", avl_ready); end
    tick();
    total++;
    if ({cmd_valid, cmd_id} !== {1'b1, exp_id}) begin
      bad++; $display("FAIL acc_with_cmpl got=%h exp=%h", {cmd_valid, cmd_id}, {1'b1, exp_id});
    end
    exp_id++;
    itf_rvalid = 1'b0; itf_rlast = 1'b0; #1;
    total++;
    if (avl_ready !== 1'b1) begin bad++; $display("FAIL pending_unchanged got=%b exp=1", avl_ready); end
    tick(); exp_id++;
    rd_req = 1'b0; #1;
    total++;
    if (avl_ready !== 1'b0) begin bad++; $display("FAIL refull got=%b exp=0", avl_ready); end
    itf_rvalid = 1'b1; itf_rlast = 1'b1;
    repeat (16) tick();
    itf_rvalid = 1'b0; itf_rlast = 1'b0; #1;
    total++;
    if (avl_ready !== 1'b1) begin bad++; $display("FAIL drained got=%b exp=1", avl_ready); end
  endtask

  task automatic test_id_wrap();
    wr_req = 1'b1; size = 3'd1; wdata = 64'h5A;
    for (int i = 0; i < 260; i++) begin
      tick();
      total++;
      if ({cmd_valid, cmd_id, wr_valid, wr_id} !== {1'b1, exp_id, 1'b1, exp_id}) begin
        bad++; $display("FAIL wrap_id%0d got=%h exp=%h", i, {cmd_valid, cmd_id, wr_valid, wr_id},
          {1'b1, exp_id, 1'b1, exp_id});
      end
      exp_id++;
    end
    wr_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    wr_req = 1'b1; size = 3'd4; wdata = 64'hC0;
    tick(); wdata = 64'hC1;
    tick(); wr_req = 1'b0;
    itf_rvalid = 1'b1; itf_rdata = 64'hDD;
    #2 rst_n = 1'b0; #1;
    total++;
    if ({cmd_valid, wr_valid, rvalid, rd_ready, avl_ready} !== 5'b0) begin
      bad++; $display("FAIL mid_reset got=%b exp=00000", {cmd_valid, wr_valid, rvalid, rd_ready, avl_ready});
    end
    itf_rvalid = 1'b0;
    #7 rst_n = 1'b1;
    tick();
    rd_req = 1'b1; addr = 33'h200; size = 3'd1;
    tick(); rd_req = 1'b0;
    total++;
    if ({cmd_valid, cmd, cmd_id} !== {1'b1, 1'b0, 8'd0}) begin
      bad++; $display("FAIL post_reset_id got=%h exp=%h", {cmd_valid, cmd, cmd_id}, {1'b1, 1'b0, 8'd0});
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_backpressure();
    test_max_pending();
    test_id_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
